instr_mem_responder: RTL and testbench

Responder end of the instruction-fetch memory handshake (req/gnt/rvalid/rdata), serving the fetch stage from a word-addressed on-chip instruction RAM. Accepts fetch requests, returns read data in order after a fixed, configurable latency, and limits the number of in-flight requests. A side-band load port lets the boot loader or testbench write the program image.

---
 rtl/instr_mem_pkg.sv | 14 +
 rtl/instr_mem_array.sv | 35 +++
 rtl/instr_mem_responder.sv | 126 ++++++++++++
 tb/tb_instr_mem_responder.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/instr_mem_pkg.sv
// Shared types and constants for the instruction-memory responder slice.
package instr_mem_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h00000013;
  localparam int LATENCY_MAX = 4;
  localparam int OUTSTANDING_MAX = 4;

  typedef struct packed {
    logic            err;
    logic [XLEN-1:0] data;
  } resp_t;

endpackage

// File: rtl/instr_mem_array.sv
// Word-addressed synchronous instruction RAM: one registered read port, one write port.
import instr_mem_pkg::*;

module instr_mem_array #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rd_en,
  input  logic [AW-1:0]   rd_addr,
  output logic [XLEN-1:0] rd_data,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [XLEN-1:0] wr_data
);

  logic [XLEN-1:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read sees the pre-write contents on a same-edge collision; only the output register resets.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/instr_mem_responder.sv
// Fetch-side responder: grants requests, reads the instruction RAM and returns
// in-order responses after a fixed latency with a bounded number in flight.
import instr_mem_pkg::*;

module instr_mem_responder #(
  parameter int DEPTH_WORDS     = 1024,
  parameter int LATENCY         = 1,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic            clk_in,
  input  logic            rst_in,
  input  logic            instr_req_in,
  input  logic [XLEN-1:0] instr_addr_in,
  output logic            gnt_out,
  output logic            instr_rvalid_out,
  output logic [XLEN-1:0] instr_rdata_out,
  output logic            instr_err_out,
  input  logic            load_we_in,
  input  logic [XLEN-1:0] load_addr_in,
  input  logic [XLEN-1:0] load_data_in
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int CW = $clog2(OUTSTANDING_MAX + 1);

  logic            in_range;
  logic            load_in_range;
  logic            accept;
  logic            retiring;
  logic [CW-1:0]   count_q;
  logic            vld0_q;
  logic            err0_q;
  logic [XLEN-1:0] ram_rdata;
  resp_t           resp0;
  resp_t           resp_out;

  // Full-width compares so high address bits can never alias into the array.
  assign in_range      = instr_addr_in < XLEN'(DEPTH_WORDS);
  assign load_in_range = load_addr_in < XLEN'(DEPTH_WORDS);

  assign retiring = instr_rvalid_out;
  assign gnt_out  = instr_req_in && !rst_in &&
                    ((count_q < CW'(MAX_OUTSTANDING)) || retiring);
  assign accept   = gnt_out;

  instr_mem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_array (
    .clk    (clk_in),
    .rst    (rst_in),
    .rd_en  (accept && in_range),
    .rd_addr(instr_addr_in[AW-1:0]),
    .rd_data(ram_rdata),
    .wr_en  (load_we_in && load_in_range),
    .wr_addr(load_addr_in[AW-1:0]),
    .wr_data(load_data_in)
  );

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      count_q <= '0;
    end else if (accept && !retiring) begin
      count_q <= count_q + CW'(1);
    end else if (!accept && retiring) begin
      count_q <= count_q - CW'(1);
    end
  end

  // First stage lines up with the RAM read register.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      vld0_q <= 1'b0;
      err0_q <= 1'b0;
    end else begin
      vld0_q <= accept;
      if (accept) begin
        err0_q <= !in_range;
      end
    end
  end

  always_comb begin
    resp0      = '0;
    resp0.err  = err0_q;
    resp0.data = err0_q ? NOP_INSTR : ram_rdata;
  end

  generate
    if (LATENCY <= 1) begin : g_direct
      assign instr_rvalid_out = vld0_q;
      assign resp_out         = resp0;
    end else begin : g_pipe
      resp_t              pipe_q [LATENCY-1];
      logic [LATENCY-2:0] vld_q;

      // Stages only load when a response moves into them, so outputs hold between responses.
      always_ff @(posedge clk_in) begin
        if (rst_in) begin
          vld_q <= '0;
          for (int i = 0; i < LATENCY - 1; i++) begin
            pipe_q[i] <= '0;
          end
        end else begin
          vld_q[0] <= vld0_q;
          if (vld0_q) begin
            pipe_q[0] <= resp0;
          end
          for (int i = 1; i < LATENCY - 1; i++) begin
            vld_q[i] <= vld_q[i-1];
            if (vld_q[i-1]) begin
              pipe_q[i] <= pipe_q[i-1];
            end
          end
        end
      end

      assign instr_rvalid_out = vld_q[LATENCY-2];
      assign resp_out         = pipe_q[LATENCY-2];
    end
  endgenerate

  assign instr_rdata_out = resp_out.data;
  assign instr_err_out   = resp_out.err;

endmodule

// File: tb/tb_instr_mem_responder.sv
// Randomized self-checking bench: three responder configurations share one stimulus
// stream and are each compared against a transaction-level queue model.
module tb_instr_mem_responder;
  import instr_mem_pkg::*;

  localparam int DEPTH = 1024;
  localparam int ND    = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic [31:0] addr;
  logic        we;
  logic [31:0] laddr;
  logic [31:0] ldata;

  logic [ND-1:0] gnt_w;
  logic [ND-1:0] rvalid_w;
  logic [ND-1:0] err_w;
  logic [31:0]   rdata_w [ND];

  int checks = 0;
  int errors = 0;

  // Reference model: program image plus per-configuration FIFO of pending responses.
  logic [31:0] mem_m [DEPTH];
  int          cyc;
  int          cnt    [ND];
  int          due_m  [ND][8];
  logic [31:0] dat_m  [ND][8];
  logic        err_m  [ND][8];
  logic [31:0] last_d [ND];
  logic        last_e [ND];

  always #5 clk = ~clk;

  instr_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(1), .MAX_OUTSTANDING(2)) u_dut0 (
    .clk_in(clk), .rst_in(rst), .instr_req_in(req), .instr_addr_in(addr),
    .gnt_out(gnt_w[0]), .instr_rvalid_out(rvalid_w[0]), .instr_rdata_out(rdata_w[0]),
    .instr_err_out(err_w[0]), .load_we_in(we), .load_addr_in(laddr), .load_data_in(ldata)
  );

  instr_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(3), .MAX_OUTSTANDING(2)) u_dut1 (
    .clk_in(clk), .rst_in(rst), .instr_req_in(req), .instr_addr_in(addr),
    .gnt_out(gnt_w[1]), .instr_rvalid_out(rvalid_w[1]), .instr_rdata_out(rdata_w[1]),
    .instr_err_out(err_w[1]), .load_we_in(we), .load_addr_in(laddr), .load_data_in(ldata)
  );

  instr_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(4), .MAX_OUTSTANDING(1)) u_dut2 (
    .clk_in(clk), .rst_in(rst), .instr_req_in(req), .instr_addr_in(addr),
    .gnt_out(gnt_w[2]), .instr_rvalid_out(rvalid_w[2]), .instr_rdata_out(rdata_w[2]),
    .instr_err_out(err_w[2]), .load_we_in(we), .load_addr_in(laddr), .load_data_in(ldata)
  );

  function automatic int lat_of(input int d);
    case (d)
      0:       return 1;
      1:       return 3;
      default: return 4;
    endcase
  endfunction

  function automatic int max_of(input int d);
    case (d)
      0:       return 2;
      1:       return 2;
      default: return 1;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check grant, advance the model, check responses.
  task automatic applyStimulus(input logic r_req, input logic [31:0] r_addr,
                               input logic l_we, input logic [31:0] l_addr,
                               input logic [31:0] l_data, input logic r_rst);
    logic       exp_g;
    logic       exp_v;
    logic       acc [ND];
    logic [31:0] rd_old;
    @(negedge clk);
    req   = r_req;
    addr  = r_addr;
    we    = l_we;
    laddr = l_addr;
    ldata = l_data;
    rst   = r_rst;
    #1;
    for (int d = 0; d < ND; d++) begin
      exp_g = r_req && !r_rst &&
              ((cnt[d] < max_of(d)) || (cnt[d] > 0 && due_m[d][0] == cyc));
      acc[d] = exp_g;
      checkOutput($sformatf("gnt[%0d]", d), {31'b0, gnt_w[d]}, {31'b0, exp_g});
    end
    rd_old = (r_addr < DEPTH) ? mem_m[r_addr[9:0]] : NOP_INSTR;
    @(posedge clk);
    cyc++;
    for (int d = 0; d < ND; d++) begin
      if (r_rst) begin
        cnt[d]    = 0;
        last_d[d] = '0;
        last_e[d] = 1'b0;
      end else begin
        if (cnt[d] > 0 && due_m[d][0] == cyc - 1) begin
          for (int j = 0; j < 7; j++) begin
            due_m[d][j] = due_m[d][j+1];
            dat_m[d][j] = dat_m[d][j+1];
            err_m[d][j] = err_m[d][j+1];
          end
          cnt[d]--;
        end
        if (acc[d]) begin
          due_m[d][cnt[d]] = cyc + lat_of(d) - 1;
          dat_m[d][cnt[d]] = rd_old;
          err_m[d][cnt[d]] = (r_addr >= DEPTH);
          cnt[d]++;
        end
      end
    end
    if (l_we && l_addr < DEPTH) mem_m[l_addr[9:0]] = l_data;
    #1;
    for (int d = 0; d < ND; d++) begin
      exp_v = cnt[d] > 0 && due_m[d][0] == cyc;
      if (exp_v) begin
        last_d[d] = dat_m[d][0];
        last_e[d] = err_m[d][0];
      end
      checkOutput($sformatf("rvalid[%0d]", d), {31'b0, rvalid_w[d]}, {31'b0, exp_v});
      checkOutput($sformatf("rdata[%0d]", d), rdata_w[d], last_d[d]);
      checkOutput($sformatf("err[%0d]", d), {31'b0, err_w[d]}, {31'b0, last_e[d]});
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] v);
    applyStimulus(1'b0, '0, 1'b1, a, v, 1'b0);
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] la;
    int          sel;
    rst = 1'b1; req = 1'b0; addr = '0; we = 1'b0; laddr = '0; ldata = '0;
    cyc = 0;
    for (int d = 0; d < ND; d++) begin
      cnt[d] = 0; last_d[d] = '0; last_e[d] = 1'b0;
    end

    $display("[TB] reset and program image load");
    applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b1);
    applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b1);
    for (int a = 0; a < DEPTH; a++) load(a, $urandom);
    load(0, 11); load(1, 22); load(2, 33); load(3, 44); load(5, 32'h5555);

    $display("[TB] back-to-back fetch of words 0..3");
    for (int a = 0; a < 4; a++) applyStimulus(1'b1, a, 1'b0, '0, '0, 1'b0);
    idle(6);

    $display("[TB] out-of-range fetches then in-range fetch");
    applyStimulus(1'b1, 32'd1024, 1'b0, '0, '0, 1'b0);
    idle(5);
    applyStimulus(1'b1, 32'h8000_0002, 1'b0, '0, '0, 1'b0);
    idle(5);
    applyStimulus(1'b1, 32'd2, 1'b0, '0, '0, 1'b0);
    idle(5);

    $display("[TB] load/read collision and ignored out-of-range load");
    applyStimulus(1'b1, 32'd5, 1'b1, 32'd5, 32'hAAAA, 1'b0);
    idle(5);
    load(32'd1029, 32'hDEAD_BEEF);
    load(32'h0001_0005, 32'hBAD0_BAD0);
    applyStimulus(1'b1, 32'd5, 1'b0, '0, '0, 1'b0);
    idle(5);

    $display("[TB] held request, throttling by outstanding limit");
    for (int i = 0; i < 12; i++) applyStimulus(1'b1, i, 1'b0, '0, '0, 1'b0);
    idle(6);

    $display("[TB] reset with requests in flight");
    applyStimulus(1'b1, 32'd6, 1'b0, '0, '0, 1'b0);
    applyStimulus(1'b1, 32'd7, 1'b0, '0, '0, 1'b0);
    applyStimulus(1'b1, 32'd8, 1'b0, '0, '0, 1'b1);
    idle(6);
    applyStimulus(1'b1, 32'd3, 1'b0, '0, '0, 1'b0);

    $display("[TB] idle window");
    idle(20);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 600; i++) begin
      sel = $urandom_range(0, 9);
      if (sel == 0)      ra = 32'd1024 + $urandom_range(0, 3);
      else if (sel == 1) ra = $urandom;
      else               ra = $urandom_range(0, 31);
      la = ($urandom_range(0, 7) == 0) ? (32'd1024 + $urandom_range(0, 40)) : $urandom_range(0, 31);
      applyStimulus($urandom_range(0, 9) < 7, ra, $urandom_range(0, 3) == 0, la, $urandom,
                    $urandom_range(0, 49) == 0);
    end
    idle(6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
